data_mem_arbiter: RTL

//  Shares the data memory's scalar port and vector port between two requesters:
//  the scalar load/store unit and the vector load/store unit.
//  It sequences each access, drives the memory strobes and latched address/data, and returns read data.

---
 rtl/data_mem_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Shares the data memory's scalar and vector ports between the scalar and
//   vector load/store units. Each access is sequenced through an ACC phase
//   (registered one-hot strobes, latched address/data) and a RESP phase
//   (read data capture). Simultaneous requests are resolved round-robin.
//   Optional feature: define ADDR_CHECK_EN to flag accesses whose address
//   bits above ADDR_BITS are non-zero (granted, no strobe, err pulse, reads
//   return zero). Without it, err stays 0 and addresses pass through as-is.
module data_mem_arbiter #(
  parameter int N          = 24,
  parameter int VW         = 256,
  parameter int ADDR_BITS  = 14,
  parameter int VEC_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_req,
  input  logic          s_we,
  input  logic [N-1:0]  s_addr,
  input  logic [N-1:0]  s_wdata,
  output logic          s_gnt,
  output logic          s_rvalid,
  output logic [N-1:0]  s_rdata,
  input  logic          v_req,
  input  logic          v_we,
  input  logic [N-1:0]  v_addr,
  input  logic [VW-1:0] v_wdata,
  output logic          v_gnt,
  output logic          v_rvalid,
  output logic [VW-1:0] v_rdata,
  output logic [N-1:0]  scalar_data_address,
  output logic [N-1:0]  write_scalar_data,
  output logic [N-1:0]  vector_data_address,
  output logic [VW-1:0] write_vector_data,
  output logic          ScalarMemRead,
  output logic          ScalarMemWrite,
  output logic          VectorMemRead,
  output logic          VectorMemWrite,
  input  logic [N-1:0]  scalar_data_read,
  input  logic [VW-1:0] vector_data,
  output logic          busy,
  output logic          err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    S_ACC  = 3'd1,
    S_RESP = 3'd2,
    V_ACC  = 3'd3,
    V_RESP = 3'd4
  } state_t;

  localparam int CW = $clog2(VEC_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(VEC_CYCLES - 1);

`ifdef ADDR_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  state_t        state;
  logic [CW-1:0] vec_cnt;
  logic          last_grant_v;
  logic          lat_we;
  logic          lat_bad;

  logic          s_out_of_range;
  logic          v_out_of_range;
  logic          pick_s;
  logic          pick_v;

  // Out-of-range detection on the incoming addresses; constant 0 when the check is disabled
  assign s_out_of_range = CHECK_EN && (s_addr[N-1:ADDR_BITS] != '0);
  assign v_out_of_range = CHECK_EN && (v_addr[N-1:ADDR_BITS] != '0);

  // Round-robin choice: on a tie the requester that was not granted last wins
  always_comb begin
    pick_s = 1'b0;
    pick_v = 1'b0;
    if (s_req && (!v_req || last_grant_v)) begin
      pick_s = 1'b1;
    end else if (v_req) begin
      pick_v = 1'b1;
    end
  end

  assign busy = (state != IDLE);

  // Access sequencer: state, vector hold counter and every registered output
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      vec_cnt             <= '0;
      last_grant_v        <= 1'b1;
      lat_we              <= 1'b0;
      lat_bad             <= 1'b0;
      s_gnt               <= 1'b0;
      v_gnt               <= 1'b0;
      s_rvalid            <= 1'b0;
      v_rvalid            <= 1'b0;
      s_rdata             <= '0;
      v_rdata             <= '0;
      scalar_data_address <= '0;
      write_scalar_data   <= '0;
      vector_data_address <= '0;
      write_vector_data   <= '0;
      ScalarMemRead       <= 1'b0;
      ScalarMemWrite      <= 1'b0;
      VectorMemRead       <= 1'b0;
      VectorMemWrite      <= 1'b0;
      err                 <= 1'b0;
    end else begin
      s_gnt    <= 1'b0;
      v_gnt    <= 1'b0;
      s_rvalid <= 1'b0;
      v_rvalid <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_s) begin
            state               <= S_ACC;
            last_grant_v        <= 1'b0;
            s_gnt               <= 1'b1;
            scalar_data_address <= s_addr;
            write_scalar_data   <= s_wdata;
            lat_we              <= s_we;
            lat_bad             <= s_out_of_range;
            err                 <= s_out_of_range;
            ScalarMemRead       <= !s_we && !s_out_of_range;
            ScalarMemWrite      <= s_we && !s_out_of_range;
          end else if (pick_v) begin
            state               <= V_ACC;
            last_grant_v        <= 1'b1;
            v_gnt               <= 1'b1;
            vec_cnt             <= CNT_LOAD;
            vector_data_address <= v_addr;
            write_vector_data   <= v_wdata;
            lat_we              <= v_we;
            lat_bad             <= v_out_of_range;
            err                 <= v_out_of_range;
            VectorMemRead       <= !v_we && !v_out_of_range;
            VectorMemWrite      <= v_we && !v_out_of_range;
          end
        end
        S_ACC: begin
          state          <= S_RESP;
          ScalarMemRead  <= 1'b0;
          ScalarMemWrite <= 1'b0;
        end
        S_RESP: begin
          state <= IDLE;
          if (!lat_we) begin
            s_rdata  <= lat_bad ? '0 : scalar_data_read;
            s_rvalid <= 1'b1;
          end
        end
        V_ACC: begin
          if (vec_cnt == '0) begin
            state          <= V_RESP;
            VectorMemRead  <= 1'b0;
            VectorMemWrite <= 1'b0;
          end else begin
            vec_cnt <= vec_cnt - CW'(1);
          end
        end
        V_RESP: begin
          state <= IDLE;
          if (!lat_we) begin
            v_rdata  <= lat_bad ? '0 : vector_data;
            v_rvalid <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
